// File: rtl/mem_arbiter_if.sv
// Requester, RAM and debug signals shared by the two-port RAM arbiter.

typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
} mem_arbiter_state_t;

interface mem_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          ack0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          ack1;

    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [1:0]    STATE;

    // Arbiter side
    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        output gnt0, ack0, gnt1, ack1, rdata, mem_addr, mem_wdata, mem_we, busy, STATE
    );

    // Requester / RAM side
    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        input  gnt0, ack0, gnt1, ack1, rdata, mem_addr, mem_wdata, mem_we, busy, STATE
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between
// the CPU path (port 0) and the IO/loader path (port 1).

module mem_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    mem_arbiter_state_t state_q, state_d;

    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          mem_we_q, mem_we_d;
    logic          busy_q, busy_d;
    logic          pick;

    // Winner of this IDLE cycle: the lone requester, or on a tie the port not served last
    assign pick = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    // Next state, captured request and next registered outputs
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        mem_we_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d  = ACCESS;
                    sel_d    = pick;
                    addr_d   = pick ? bus.addr1  : bus.addr0;
                    wdata_d  = pick ? bus.wdata1 : bus.wdata0;
                    mem_we_d = pick ? bus.we1    : bus.we0;
                    gnt0_d   = ~pick;
                    gnt1_d   = pick;
                end
            end
            ACCESS: begin
                state_d = ACK;
                gnt0_d  = ~sel_q;
                gnt1_d  = sel_q;
                ack0_d  = ~sel_q;
                ack1_d  = sel_q;
            end
            ACK: begin
                state_d = IDLE;
                last_d  = sel_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            mem_we_q <= mem_we_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;
    assign bus.STATE     = state_q;
    // RAM read data passes straight through; requesters sample it during ack
    assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural synchronous RAM.

module tb_mem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic reset;
    logic preload;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous RAM: write and registered read on the rising edge
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
            ram[8'h10] <= 8'h5A;
            ram[8'h30] <= 8'h77;
            ram[8'h31] <= 8'h88;
            ram[8'h40] <= 8'h11;
        end else begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct { logic port; logic [7:0] data; logic chk; } exp_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
    exp_t ack_q[$];
    wr_t  wr_q[$];

    // Monitor: pops expectations whenever the DUT acks or strobes a write
    exp_t e;
    wr_t  w;
    always @(negedge clk) begin
        if (!reset) begin
            check("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 32'd0);
            check("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
            if (bus.ack0 || bus.ack1) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ack_unexpected: ack0=%0b ack1=%0b required none", bus.ack0, bus.ack1);
                end else begin
                    e = ack_q.pop_front();
                    check("ack_port", 32'(bus.ack1), 32'(e.port));
                    if (e.chk) check("rdata", 32'(bus.rdata), 32'(e.data));
                end
            end
            if (bus.mem_we) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL we_unexpected: mem_we=1 addr=%0h required no write", bus.mem_addr);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
                    check("wr_data", 32'(bus.mem_wdata), 32'(w.data));
                end
            end
        end
    end

    // Single transaction on one port with grant/ack/strobe cycle counting
    task automatic txn(input logic port, input logic we, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_rd, input string tag);
        int g_own = 0;
        int a_own = 0;
        int other = 0;
        int we_cnt = 0;
        ack_q.push_back('{port, exp_rd, ~we});
        if (we) wr_q.push_back('{addr, wdata});
        @(negedge clk);
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (port ? bus.gnt1 : bus.gnt0) g_own++;
            if (port ? bus.gnt0 : bus.gnt1) other++;
            if (port ? bus.ack0 : bus.ack1) other++;
            if (bus.mem_we) we_cnt++;
            if (port ? bus.ack1 : bus.ack0) begin
                a_own++;
                if (port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check({tag, "_gnt_cycles"}, 32'(g_own), 32'd2);
        check({tag, "_ack_cycles"}, 32'(a_own), 32'd1);
        check({tag, "_other_port"}, 32'(other), 32'd0);
        check({tag, "_we_cycles"}, 32'(we_cnt), 32'(we));
    endtask

    mem_arbiter_state_t bad_state;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int a0, a1, n_grants, first_port;
        logic [3:0] order;
        bad_state = mem_arbiter_state_t'(2'd3);
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        preload = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        preload = 1'b0;

        check("rst_gnt0",   32'(bus.gnt0),      32'd0);
        check("rst_gnt1",   32'(bus.gnt1),      32'd0);
        check("rst_ack0",   32'(bus.ack0),      32'd0);
        check("rst_ack1",   32'(bus.ack1),      32'd0);
        check("rst_mem_we", 32'(bus.mem_we),    32'd0);
        check("rst_busy",   32'(bus.busy),      32'd0);
        check("rst_state",  32'(bus.STATE),     32'd0);
        check("rst_addr",   32'(bus.mem_addr),  32'd0);
        check("rst_wdata",  32'(bus.mem_wdata), 32'd0);
        reset = 1'b0;

        // Basic read, write, read-back
        txn(1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, "t1_rd");
        txn(1'b1, 1'b1, 8'h20, 8'hC3, 8'h00, "t2_wr");
        txn(1'b0, 1'b0, 8'h20, 8'h00, 8'hC3, "t2_rdback");

        // Both ports held for 12 cycles after reset: 0,1,0,1
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        ack_q.push_back('{1'b0, 8'h5A, 1'b1});
        ack_q.push_back('{1'b1, 8'hC3, 1'b1});
        ack_q.push_back('{1'b0, 8'h5A, 1'b1});
        ack_q.push_back('{1'b1, 8'hC3, 1'b1});
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
        a0 = 0; a1 = 0; n_grants = 0; order = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.ack0) a0++;
            if (bus.ack1) a1++;
            if ((bus.gnt0 || bus.gnt1) && !(bus.ack0 || bus.ack1) && n_grants < 4) begin
                order[n_grants] = bus.gnt1;
                n_grants++;
            end
            if (i == 11) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        check("t3_ack0_count", 32'(a0), 32'd2);
        check("t3_ack1_count", 32'(a1), 32'd2);
        check("t3_grant_order", 32'(order), 32'b1010);

        // Address change and req drop after grant do not disturb the access
        ack_q.push_back('{1'b0, 8'h77, 1'b1});
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h30;
        @(negedge clk);
        check("t4_gnt0", 32'(bus.gnt0), 32'd1);
        check("t4_mem_addr", 32'(bus.mem_addr), 32'h30);
        bus.addr0 = 8'h31;
        bus.req0  = 1'b0;
        a0 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.ack0) a0++;
        end
        check("t4_ack0_count", 32'(a0), 32'd1);

        // Reset during a port 1 write
        @(negedge clk);
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h40; bus.wdata1 = 8'h99;
        @(posedge clk); #1;
        check("t5_we_before", 32'(bus.mem_we), 32'd1);
        check("t5_gnt1_before", 32'(bus.gnt1), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("t5_we_after", 32'(bus.mem_we), 32'd0);
        check("t5_gnt1_after", 32'(bus.gnt1), 32'd0);
        check("t5_state_after", 32'(bus.STATE), 32'd0);
        check("t5_busy_after", 32'(bus.busy), 32'd0);
        @(negedge clk); bus.req1 = 1'b0; bus.we1 = 1'b0;
        @(negedge clk); reset = 1'b0;
        check("t5_ram_untouched", 32'(ram[8'h40]), 32'h11);

        // First tie after reset goes to port 0
        ack_q.push_back('{1'b0, 8'h5A, 1'b1});
        ack_q.push_back('{1'b1, 8'hC3, 1'b1});
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
        first_port = -1; a0 = 0; a1 = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (first_port < 0 && (bus.gnt0 || bus.gnt1)) first_port = bus.gnt1 ? 1 : 0;
            if (bus.ack0) a0++;
            if (bus.ack1) a1++;
            if (i == 5) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        check("t5_tie_first", 32'(first_port), 32'd0);
        check("t5_tie_ack0", 32'(a0), 32'd1);
        check("t5_tie_ack1", 32'(a1), 32'd1);

        // Illegal state encoding recovers to IDLE with outputs cleared
        wr_q.push_back('{8'h50, 8'h42});
        @(negedge clk);
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h50; bus.wdata1 = 8'h42;
        @(posedge clk); #2;
        force dut.state_q = bad_state;
        @(posedge clk); #1;
        release dut.state_q;
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        check("t6_gnt0", 32'(bus.gnt0), 32'd0);
        check("t6_gnt1", 32'(bus.gnt1), 32'd0);
        check("t6_ack0", 32'(bus.ack0), 32'd0);
        check("t6_ack1", 32'(bus.ack1), 32'd0);
        check("t6_mem_we", 32'(bus.mem_we), 32'd0);
        @(posedge clk); #1;
        check("t6_state_idle", 32'(bus.STATE), 32'd0);
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_gnt1_idle", 32'(bus.gnt1), 32'd0);

        repeat (3) @(negedge clk);
        check("sb_ack_drained", 32'(ack_q.size()), 32'd0);
        check("sb_wr_drained", 32'(wr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
